// File: rtl/wb_exc_ctrl_if.sv
// ============================================================================
// Module  : wb_exc_ctrl_if
// Brief   : MEM-to-WB handshake and retiring-instruction payload bundle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_exc_ctrl_if;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [1:0]  ms_csr_op;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_rj_value;
   logic [31:0] ms_rkd_value;
   logic [5:0]  ms_exc_flags;
   logic        ms_ertn;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_result;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value,
             ms_rkd_value, ms_exc_flags, ms_ertn, ms_gr_we, ms_dest, ms_result,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value,
             ms_rkd_value, ms_exc_flags, ms_ertn, ms_gr_we, ms_dest, ms_result,
      output ws_allowin
   );
endinterface

`default_nettype wire

// File: rtl/wb_exc_ctrl.sv
// ============================================================================
// Module  : wb_exc_ctrl
// Brief   : Write-back controller: CSR access decode, exception/ertn commit
//           and timed pipeline flush with fetch redirect.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wb_exc_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   wb_exc_ctrl_if.slave ms,
   output logic [13:0] csr_num,
   input  logic [31:0] csr_rdata,
   output logic        csr_we,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wdata,
   output logic        exc_signal,
   output logic        ertn_signal,
   output logic [5:0]  exc_ecode,
   output logic [8:0]  exc_esubcode,
   output logic [31:0] exc_pc,
   input  logic [31:0] csr_2_if_pc,
   output logic [31:0] flush_pc,
   output logic        flush,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   localparam int                 c_CNT_W    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_ws_valid;
   logic [31:0]        r_pc;
   logic [1:0]         r_csr_op;
   logic [13:0]        r_csr_num;
   logic [31:0]        r_rj_value;
   logic [31:0]        r_rkd_value;
   logic [5:0]         r_exc_flags;
   logic               r_ertn;
   logic               r_gr_we;
   logic [4:0]         r_dest;
   logic [31:0]        r_result;

   logic               w_idle;
   logic               w_commit;
   logic               w_exc;
   logic               w_redirect;
   logic               w_hs;
   logic [5:0]         w_ecode;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_commit   = r_ws_valid & w_idle;
   assign w_exc      = |r_exc_flags;
   assign w_redirect = w_commit & (w_exc | r_ertn);
   assign w_hs       = ms.ms_to_ws_valid & w_idle;

   assign ms.ws_allowin = w_idle;

   // An instruction arriving while the current one redirects is being killed upstream.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_ws_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_redirect) begin
                  r_state    <= ST_FLUSH;
                  r_cnt      <= c_CNT_LOAD;
                  r_ws_valid <= 1'b0;
               end else begin
                  r_ws_valid <= w_hs;
               end
            end
            ST_FLUSH: begin
               r_ws_valid <= 1'b0;
               if (r_cnt == c_CNT_ONE) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_cnt      <= '0;
               r_ws_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pc        <= '0;
         r_csr_op    <= '0;
         r_csr_num   <= '0;
         r_rj_value  <= '0;
         r_rkd_value <= '0;
         r_exc_flags <= '0;
         r_ertn      <= 1'b0;
         r_gr_we     <= 1'b0;
         r_dest      <= '0;
         r_result    <= '0;
      end else if (w_hs && !w_redirect) begin
         r_pc        <= ms.ms_pc;
         r_csr_op    <= ms.ms_csr_op;
         r_csr_num   <= ms.ms_csr_num;
         r_rj_value  <= ms.ms_rj_value;
         r_rkd_value <= ms.ms_rkd_value;
         r_exc_flags <= ms.ms_exc_flags;
         r_ertn      <= ms.ms_ertn;
         r_gr_we     <= ms.ms_gr_we;
         r_dest      <= ms.ms_dest;
         r_result    <= ms.ms_result;
      end
   end

   // Flag bits are {ALE,BRK,SYS,INE,ADEF,INT}; lower bit wins.
   always_comb begin
      w_ecode = 6'h00;
      if      (r_exc_flags[0]) w_ecode = 6'h00;
      else if (r_exc_flags[1]) w_ecode = 6'h08;
      else if (r_exc_flags[2]) w_ecode = 6'h0D;
      else if (r_exc_flags[3]) w_ecode = 6'h0B;
      else if (r_exc_flags[4]) w_ecode = 6'h0C;
      else if (r_exc_flags[5]) w_ecode = 6'h09;
   end

   always_comb begin
      csr_wmask = 32'h0;
      if (w_commit) begin
         if (r_csr_op == 2'b10)      csr_wmask = 32'hFFFF_FFFF;
         else if (r_csr_op == 2'b11) csr_wmask = r_rj_value;
      end
   end

   assign csr_num      = w_commit ? r_csr_num : 14'h0;
   assign csr_we       = w_commit & ~w_exc & r_csr_op[1];
   assign csr_wdata    = w_commit ? r_rkd_value : 32'h0;

   assign exc_signal   = w_commit & w_exc;
   assign ertn_signal  = w_commit & r_ertn & ~w_exc;
   assign exc_ecode    = exc_signal ? w_ecode : 6'h00;
   assign exc_esubcode = 9'h000;
   assign exc_pc       = w_commit ? r_pc : 32'h0;

   assign flush        = w_redirect | (r_state == ST_FLUSH);
   assign flush_pc     = csr_2_if_pc;

   // CSR instructions return the pre-write CSR value to the GPR.
   assign rf_we        = w_commit & r_gr_we & ~w_exc;
   assign rf_waddr     = w_commit ? r_dest : 5'h00;
   assign rf_wdata     = !w_commit            ? 32'h0     :
                         (r_csr_op != 2'b00)  ? csr_rdata : r_result;

endmodule

`default_nettype wire

// File: tb/tb_wb_exc_ctrl.sv
// ============================================================================
// Module  : tb_wb_exc_ctrl
// Brief   : Scoreboard bench for wb_exc_ctrl with directed and random traffic.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_exc_ctrl;

   localparam int F      = 2;
   localparam int N_RAND = 300;

   logic        clk = 1'b0;
   logic        resetn;
   logic [13:0] csr_num;
   logic [31:0] csr_rdata;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wdata;
   logic        exc_signal;
   logic        ertn_signal;
   logic [5:0]  exc_ecode;
   logic [8:0]  exc_esubcode;
   logic [31:0] exc_pc;
   logic [31:0] csr_2_if_pc;
   logic [31:0] flush_pc;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always #5 clk = ~clk;

   wb_exc_ctrl_if ms_if ();

   wb_exc_ctrl #(.FLUSH_CYCLES(F)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ms           (ms_if),
      .csr_num      (csr_num),
      .csr_rdata    (csr_rdata),
      .csr_we       (csr_we),
      .csr_wmask    (csr_wmask),
      .csr_wdata    (csr_wdata),
      .exc_signal   (exc_signal),
      .ertn_signal  (ertn_signal),
      .exc_ecode    (exc_ecode),
      .exc_esubcode (exc_esubcode),
      .exc_pc       (exc_pc),
      .csr_2_if_pc  (csr_2_if_pc),
      .flush_pc     (flush_pc),
      .flush        (flush),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata)
   );

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  op;
      logic [13:0] num;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic [5:0]  flags;
      logic        ertn;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
   } instr_t;

   typedef struct {
      logic        exc;
      logic        ertn;
      logic [5:0]  ecode;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] wmask;
      logic [31:0] wdata;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [31:0] pc;
   } exp_t;

   exp_t   exp_q[$];
   instr_t stim_q[$];
   int     checks   = 0;
   int     failures = 0;
   bit     mon_en   = 1'b0;

   // Simple CSR file stand-in: read value depends only on the CSR number.
   function automatic logic [31:0] csr_val(input logic [13:0] n);
      return (n == 14'h30) ? 32'h0000_00AA : ({n, 18'h15A5A} ^ 32'h0F0F_0000);
   endfunction

   always_comb csr_rdata = csr_val(csr_num);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [5:0] code_of(input int b);
      case (b)
         0: return 6'h00;
         1: return 6'h08;
         2: return 6'h0D;
         3: return 6'h0B;
         4: return 6'h0C;
         default: return 6'h09;
      endcase
   endfunction

   function automatic exp_t model(input instr_t i);
      exp_t e;
      e.exc   = |i.flags;
      e.ecode = 6'h00;
      for (int b = 5; b >= 0; b--)
         if (i.flags[b]) e.ecode = code_of(b);
      e.ertn     = i.ertn && !e.exc;
      e.csr_num  = i.num;
      e.csr_we   = !e.exc && (i.op == 2'd2 || i.op == 2'd3);
      e.wmask    = (i.op == 2'd2) ? 32'hFFFF_FFFF : (i.op == 2'd3) ? i.rj : 32'h0;
      e.wdata    = i.rkd;
      e.rf_we    = i.gr_we && !e.exc;
      e.rf_waddr = i.dest;
      e.rf_wdata = (i.op == 2'd0) ? i.result : csr_val(i.num);
      e.pc       = i.pc;
      return e;
   endfunction

   function automatic instr_t mk(input logic [1:0] op, input logic [13:0] num,
                                 input logic [31:0] rj, input logic [31:0] rkd,
                                 input logic [5:0] flags, input logic ertn,
                                 input logic [31:0] pc);
      instr_t i;
      i.pc = pc; i.op = op; i.num = num; i.rj = rj; i.rkd = rkd;
      i.flags = flags; i.ertn = ertn; i.gr_we = 1'b1;
      i.dest = 5'($urandom_range(1, 31)); i.result = $urandom;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      logic [5:0] fl;
      fl = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
      return mk(2'($urandom_range(0, 3)), 14'($urandom_range(0, 63)), $urandom, $urandom,
                fl, ($urandom_range(0, 7) == 0), $urandom);
   endfunction

   task automatic drive(input instr_t i, input bit v);
      ms_if.ms_to_ws_valid = v;
      ms_if.ms_pc          = i.pc;
      ms_if.ms_csr_op      = i.op;
      ms_if.ms_csr_num     = i.num;
      ms_if.ms_rj_value    = i.rj;
      ms_if.ms_rkd_value   = i.rkd;
      ms_if.ms_exc_flags   = i.flags;
      ms_if.ms_ertn        = i.ertn;
      ms_if.ms_gr_we       = i.gr_we;
      ms_if.ms_dest        = i.dest;
      ms_if.ms_result      = i.result;
   endtask

   // Monitor: every commit shows rf_we or exc_signal, since stimulus always sets gr_we.
   initial begin
      exp_t e;
      int   rem;
      bit   ev_flush;
      rem = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            ev_flush = 1'b0;
            if (rf_we || exc_signal) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_commit", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("exc_signal",   exc_signal,   e.exc);
                  chk("ertn_signal",  ertn_signal,  e.ertn);
                  chk("exc_ecode",    exc_ecode,    e.ecode);
                  chk("exc_esubcode", exc_esubcode, 32'd0);
                  chk("exc_pc",       exc_pc,       e.pc);
                  chk("csr_num",      csr_num,      e.csr_num);
                  chk("csr_we",       csr_we,       e.csr_we);
                  chk("csr_wmask",    csr_wmask,    e.wmask);
                  chk("csr_wdata",    csr_wdata,    e.wdata);
                  chk("rf_we",        rf_we,        e.rf_we);
                  chk("rf_waddr",     rf_waddr,     e.rf_waddr);
                  chk("rf_wdata",     rf_wdata,     e.rf_wdata);
                  chk("flush_pc",     flush_pc,     csr_2_if_pc);
                  ev_flush = e.exc || e.ertn;
               end
            end else begin
               chk("csr_we_idle",  csr_we,      32'd0);
               chk("ertn_idle",    ertn_signal, 32'd0);
            end
            chk("flush", flush, (ev_flush || rem > 0));
            rem = ev_flush ? F : ((rem > 0) ? rem - 1 : 0);
         end
      end
   end

   initial begin
      instr_t cur;
      instr_t blank;
      bit     cur_v, hs, drop, allow_exp, wb_full, wb_flush, done;
      int     blk, n_dir, popped;

      blank = mk(2'd0, 14'h0, 32'h0, 32'h0, 6'h0, 1'b0, 32'h0);
      blank.gr_we = 1'b0; blank.dest = 5'h0; blank.result = 32'h0;
      cur = blank;
      csr_2_if_pc = 32'h1C00_8000 | ($urandom & 32'h0000_0FFC);
      resetn = 1'b0;
      drive(blank, 1'b0);

      #3;
      chk("reset_allowin",    ms_if.ws_allowin, 32'd1);
      chk("reset_flush",      flush,            32'd0);
      chk("reset_exc",        exc_signal,       32'd0);
      chk("reset_ertn",       ertn_signal,      32'd0);
      chk("reset_csr_we",     csr_we,           32'd0);
      chk("reset_rf_we",      rf_we,            32'd0);
      chk("reset_rf_wdata",   rf_wdata,         32'd0);
      chk("reset_csr_num",    csr_num,          32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      mon_en = 1'b1;

      stim_q.push_back(mk(2'd2, 14'h30, 32'h0,       32'h1234_5678, 6'h00, 1'b0, 32'h1C00_0000));
      stim_q.push_back(mk(2'd3, 14'h05, 32'h0000_FF00, 32'hDEAD_BEEF, 6'h00, 1'b0, 32'h1C00_0004));
      stim_q.push_back(mk(2'd1, 14'h06, 32'h0,       32'h0,         6'h00, 1'b0, 32'h1C00_0008));
      stim_q.push_back(mk(2'd2, 14'h07, 32'h0,       32'h1111_2222, 6'h0C, 1'b0, 32'h1C00_0100));
      stim_q.push_back(mk(2'd0, 14'h00, 32'h0,       32'h0,         6'h00, 1'b0, 32'h1C00_0104));
      stim_q.push_back(mk(2'd0, 14'h00, 32'h0,       32'h0,         6'h00, 1'b1, 32'h1C00_0200));
      stim_q.push_back(mk(2'd0, 14'h00, 32'h0,       32'h0,         6'h00, 1'b0, 32'h1C00_0204));
      stim_q.push_back(mk(2'd2, 14'h30, 32'h0,       32'h3333_4444, 6'h21, 1'b0, 32'h1C00_0300));
      stim_q.push_back(mk(2'd1, 14'h09, 32'h0,       32'h0,         6'h00, 1'b0, 32'h1C00_0304));
      n_dir = stim_q.size();
      for (int k = 0; k < N_RAND; k++) stim_q.push_back(rand_instr());

      cur_v = 1'b0; blk = 0; wb_full = 1'b0; wb_flush = 1'b0; popped = 0; done = 1'b0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         allow_exp = (blk == 0);
         chk("ws_allowin", ms_if.ws_allowin, allow_exp);
         hs   = cur_v && allow_exp;
         drop = hs && wb_full && wb_flush;
         if (hs && !drop) exp_q.push_back(model(cur));
         if (wb_full && wb_flush) blk = F;
         else if (blk > 0)        blk--;
         wb_full  = hs && !drop;
         wb_flush = wb_full && ((|cur.flags) || cur.ertn);
         if (stim_q.size() == 0 && !cur_v && !wb_full && blk == 0) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (hs || !cur_v) begin
            if (stim_q.size() > 0 && (popped < n_dir || $urandom_range(0, 3) != 0)) begin
               cur = stim_q.pop_front();
               cur_v = 1'b1;
               popped++;
            end else begin
               cur_v = 1'b0;
            end
         end
         drive(cur, cur_v);
      end
      if (!done) chk("driver_timeout", 32'd1, 32'd0);

      for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      repeat (F + 2) @(negedge clk);
      mon_en = 1'b0;

      // Reset pulled low during the first drain cycle, then a normal commit.
      @(posedge clk); #1;
      cur = mk(2'd0, 14'h0, 32'h0, 32'h0, 6'h10, 1'b0, 32'h1C00_0400);
      drive(cur, 1'b1);
      @(negedge clk);
      chk("rst_hs_allowin", ms_if.ws_allowin, 32'd1);
      @(posedge clk); #1;
      drive(cur, 1'b0);
      @(negedge clk);
      chk("rst_exc_pulse", exc_signal, 32'd1);
      chk("rst_exc_ecode", exc_ecode,  32'h0C);
      chk("rst_exc_flush", flush,      32'd1);
      @(posedge clk); #1;
      chk("rst_flush_cyc1",   flush,            32'd1);
      chk("rst_allowin_cyc1", ms_if.ws_allowin, 32'd0);
      resetn = 1'b0;
      #1;
      chk("rst_async_flush",   flush,            32'd0);
      chk("rst_async_allowin", ms_if.ws_allowin, 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      cur = mk(2'd2, 14'h30, 32'h0, 32'h0000_0055, 6'h00, 1'b0, 32'h1C00_0500);
      cur.dest = 5'd7;
      drive(cur, 1'b1);
      @(negedge clk);
      @(posedge clk); #1;
      drive(cur, 1'b0);
      @(negedge clk);
      chk("post_rst_rf_we",    rf_we,     32'd1);
      chk("post_rst_rf_waddr", rf_waddr,  32'd7);
      chk("post_rst_rf_wdata", rf_wdata,  32'h0000_00AA);
      chk("post_rst_csr_we",   csr_we,    32'd1);
      chk("post_rst_wdata",    csr_wdata, 32'h0000_0055);
      chk("post_rst_flush",    flush,     32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
